uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Downstream consumer of the UART byte receiver in the sensor-via-UART FPGA design. It edge-detects the receiver's byte-ready flag, assembles two-byte request frames (command code, then sensor address), validates both fields, and presents a decoded request to the sensor controller over a valid/ready handshake. Malformed frames, overrun and, optionally, inter-byte timeouts are flagged with an error pulse and code.

## Interface
- `TIMEOUT_CYCLES`, default 11520: inter-byte timeout in clocks (100 ms at 115200 Hz).
- `MAX_ADDR`, default 31: highest legal sensor address.
- `clk_115200hz` input 1: sole clock, same domain as the receiver.
- `reset` input 1: asynchronous, active-high.
- `data` input 8: received byte from the receiver; stable while `control` is high.
- `control` input 1: receiver byte-ready level; a byte is new on its rising edge only.
- `cmd_ready` input 1: sensor controller accepts the request.
- `cmd_valid` output 1: request pending.
- `cmd` output 4: decoded command, equal to `data[3:0]` of byte 1.
- `addr` output 5: sensor address from byte 2.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: last error cause; 0 overrun, 1 bad command, 2 bad address, 3 timeout.

## Operation
- Byte strobe is `control & ~control_d`, where `control_d` is a register with reset value 0. Only one byte is taken per rising edge, so a held-high `control` never re-triggers.
- States:
  - IDLE: waits for byte 1.
  - WAIT_ADDR: waits for byte 2.
  - ISSUE: `cmd_valid` high, waiting for `cmd_ready`.
- IDLE + strobe:
  - Legal codes are 0x03 to 0x09 inclusive. A legal code latches `cmd` and moves to WAIT_ADDR.
  - Any other code pulses `err` with `err_code`=1 and stays in IDLE.
- WAIT_ADDR + strobe:
  - A byte ≤ `MAX_ADDR` latches `addr[4:0]` and moves to ISSUE.
  - A larger byte pulses `err` with `err_code`=2 and returns to IDLE. `cmd` keeps its old value, but `cmd_valid` is not raised.
- ISSUE:
  - `cmd_valid`=1 and `cmd`/`addr` are held stable.
  - At an edge where `cmd_ready`=1, `cmd_valid` drops and the state returns to IDLE.
  - A strobe while in ISSUE is dropped: `err` pulses with `err_code`=0 and the state is unaffected.
- If a strobe and `cmd_ready` occur on the same edge in ISSUE, the handshake completes, the byte is still dropped, and the overrun error is flagged.
- `err_code` holds its value until the next error.
- Reset values: state IDLE, `cmd_valid`=0, `cmd`=0, `addr`=0, `err`=0, `err_code`=0, `control_d`=0, timeout counter 0.
- Reset mid-frame discards the partial frame. After reset, a `control` that is already high is not a strobe until it falls and rises again.

## Timing
- A byte is sampled at the edge where the strobe condition holds, i.e. the first clock after `control` rises.
- `cmd_valid` is registered. It is high starting the cycle after the edge that accepted byte 2, giving 1-clock latency from the address strobe.
- Minimum time from `cmd_valid` rise to `cmd_ready` acceptance is the same cycle if `cmd_ready` is already high; `cmd_valid` is then high for exactly one cycle.
- `err` is high for exactly one cycle following the offending edge.
- Minimum back-to-back frame spacing is 0 idle cycles: byte 1 of the next frame is accepted in the first IDLE cycle.

## Configuration
- Macro `UART_CMD_TIMEOUT_EN`.
- Defined:
  - A 14-bit counter clears on entering WAIT_ADDR and increments each cycle in WAIT_ADDR.
  - When it reaches `TIMEOUT_CYCLES-1` with no strobe, the block pulses `err` with `err_code`=3 and returns to IDLE.
  - If a strobe lands on the same edge as the timeout, the strobe wins.
- Undefined: no counter; WAIT_ADDR waits indefinitely and `err_code` 3 never occurs.

## Test plan
- Bytes 0x04 then 0x01, with `cmd_ready` held 0 then raised after 5 cycles → `cmd_valid` high for 5+1 cycles with `cmd`=4, `addr`=1, then low.
- Byte 0xAA → single-cycle `err`, `err_code`=1, state stays IDLE; a following 0x05,0x02 issues `cmd`=5, `addr`=2.
- Bytes 0x03 then 0x20 → `err`, `err_code`=2, no `cmd_valid`.
- Frame 0x06,0x00 left pending, then a third byte 0x07 → `err_code`=0, and `cmd` stays 6 until accepted.
- With `UART_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: byte 0x04 then silence → `err`, `err_code`=3, 15 cycles after the strobe edge.
- Assert `reset` in WAIT_ADDR with `control` held high → all outputs 0; no strobe until `control` toggles; then 0x09,0x1F issues `cmd`=9, `addr`=31.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: byte input, valid/ready request and error bundle for uart_cmd_decoder
interface uart_cmd_decoder_if;
  logic [7:0] data;
  logic       control;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic [4:0] addr;
  logic       err;
  logic [1:0] err_code;
  modport master (output data, control, cmd_ready, input cmd_valid, cmd, addr, err, err_code);
  modport slave (input data, control, cmd_ready, output cmd_valid, cmd, addr, err, err_code);
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles two-byte UART command frames into a valid/ready request with error reporting
// Define UART_CMD_TIMEOUT_EN to abort a frame when the address byte does not arrive within TIMEOUT_CYCLES.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 11520,
  parameter int MAX_ADDR = 31
) (
  input logic clk_115200hz,
  input logic reset,
  uart_cmd_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ADDR, ISSUE} state_t;
  state_t r_state, w_state_nx;
  logic r_control_d, r_armed, r_err;
  logic [1:0] r_err_code, w_err_code;
  logic [3:0] r_cmd;
  logic [4:0] r_addr;
  logic w_strobe, w_err, w_cmd_ld, w_addr_ld, w_timeout;
  // r_armed blocks a control level that was already high when reset released
  assign w_strobe = bus.control & ~r_control_d & r_armed;
`ifdef UART_CMD_TIMEOUT_EN
  logic [13:0] r_cnt;
  always_ff @(posedge clk_115200hz or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= (r_state == WAIT_ADDR) ? r_cnt + 14'd1 : '0;
  // fires on the edge where the counter steps onto TIMEOUT_CYCLES-1
  assign w_timeout = (r_state == WAIT_ADDR) && !w_strobe && (r_cnt == 14'(TIMEOUT_CYCLES - 2));
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_err = 1'b0;
    w_err_code = r_err_code;
    w_cmd_ld = 1'b0;
    w_addr_ld = 1'b0;
    case (r_state)
      IDLE: if (w_strobe) begin
        w_cmd_ld = (bus.data >= 8'h03) && (bus.data <= 8'h09);
        w_state_nx = w_cmd_ld ? WAIT_ADDR : IDLE;
        w_err = !w_cmd_ld;
        w_err_code = w_cmd_ld ? r_err_code : 2'd1;
      end
      WAIT_ADDR: if (w_strobe) begin
        w_addr_ld = bus.data <= 8'(MAX_ADDR);
        w_state_nx = w_addr_ld ? ISSUE : IDLE;
        w_err = !w_addr_ld;
        w_err_code = w_addr_ld ? r_err_code : 2'd2;
      end else if (w_timeout) begin
        w_state_nx = IDLE;
        w_err = 1'b1;
        w_err_code = 2'd3;
      end
      ISSUE: begin
        w_state_nx = bus.cmd_ready ? IDLE : ISSUE;
        w_err = w_strobe;
        w_err_code = w_strobe ? 2'd0 : r_err_code;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_115200hz or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_control_d <= 1'b0;
      r_armed <= 1'b0;
      r_err <= 1'b0;
      r_err_code <= 2'd0;
      r_cmd <= 4'd0;
      r_addr <= 5'd0;
    end else begin
      r_state <= w_state_nx;
      r_control_d <= bus.control;
      r_armed <= r_armed | ~bus.control;
      r_err <= w_err;
      r_err_code <= w_err_code;
      r_cmd <= w_cmd_ld ? bus.data[3:0] : r_cmd;
      r_addr <= w_addr_ld ? bus.data[4:0] : r_addr;
    end
  assign bus.cmd_valid = (r_state == ISSUE);
  assign bus.cmd = r_cmd;
  assign bus.addr = r_addr;
  assign bus.err = r_err;
  assign bus.err_code = r_err_code;
endmodule
